// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped branch target buffer.
// Predicts the next fetch PC; execute-stage redirects and BTB updates come back from resolution.
module fetch_pc_predictor #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             update_i,
    input  logic             update_taken_i,
    input  logic [WIDTH-1:0] update_pc_i,
    input  logic [WIDTH-1:0] update_target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o
);

    localparam int unsigned IW = $clog2(BTB_DEPTH);
    localparam int unsigned TW = WIDTH - IW - 2;

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q [BTB_DEPTH];
    logic [WIDTH-3:0]     tgt_q [BTB_DEPTH];

    logic [IW-1:0] rd_idx, wr_idx;
    logic [TW-1:0] rd_tag, wr_tag;
    logic          hit;
    logic          unused_low;

    assign rd_idx = pc_q[IW+1:2];
    assign rd_tag = pc_q[WIDTH-1:IW+2];
    assign wr_idx = update_pc_i[IW+1:2];
    assign wr_tag = update_pc_i[WIDTH-1:IW+2];

    // Address bits [1:0] never take part in lookup or storage.
    assign unused_low = ^{redirect_pc_i[1:0], update_pc_i[1:0], update_target_i[1:0]};

    assign hit           = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + WIDTH'(4);
    assign pred_taken_o  = hit;
    assign pred_target_o = hit ? {tgt_q[rd_idx], 2'b00} : '0;

    always_comb begin
        if (redirect_i) begin
            pc_d = {redirect_pc_i[WIDTH-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (hit) begin
            pc_d = pred_target_o;
        end else begin
            pc_d = pc_plus4_o;
        end
    end

    // A not-taken resolution only kills the entry if it actually belongs to that PC.
    always_comb begin
        valid_d = valid_q;
        if (update_i) begin
            if (update_taken_i) begin
                valid_d[wr_idx] = 1'b1;
            end else if (tag_q[wr_idx] == wr_tag) begin
                valid_d[wr_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Tag/target storage is left unreset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && update_i && update_taken_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= update_target_i[WIDTH-1:2];
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Scoreboard bench for fetch_pc_predictor: directed scenarios, then random traffic
// checked against an arithmetic reference model of the PC/BTB rules.
module tb_fetch_pc_predictor;

    localparam int unsigned       DEPTH = 16;
    localparam logic [31:0]       RPC   = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst;
    logic        stall_i, redirect_i, update_i, update_taken_i;
    logic [31:0] redirect_pc_i, update_pc_i, update_target_i;
    logic [31:0] pc_o, pc_plus4_o, pred_target_o;
    logic        pred_taken_o;

    fetch_pc_predictor #(
        .WIDTH     (32),
        .BTB_DEPTH (DEPTH),
        .RESET_PC  (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .update_i        (update_i),
        .update_taken_i  (update_taken_i),
        .update_pc_i     (update_pc_i),
        .update_target_i (update_target_i),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit [31:0] tag;
        bit [31:0] tgt;
    } ent_t;

    ent_t      btb [int];
    bit [31:0] mpc;

    function automatic int idx_of(bit [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit [31:0] tag_of(bit [31:0] a);
        return a / (4 * DEPTH);
    endfunction

    function automatic void lookup(input bit [31:0] pc, output bit h, output bit [31:0] t);
        int i;
        i = idx_of(pc);
        h = btb.exists(i) && btb[i].v && (btb[i].tag == tag_of(pc));
        t = h ? btb[i].tgt : 32'h0;
    endfunction

    function automatic void model_reset();
        btb.delete();
        mpc = RPC;
    endfunction

    function automatic void model_step(input bit st, input bit rd, input bit [31:0] rpc,
                                       input bit up, input bit tk, input bit [31:0] upc,
                                       input bit [31:0] utg);
        bit        h;
        bit [31:0] t, nxt;
        int        i;
        lookup(mpc, h, t);
        if (rd)      nxt = rpc & 32'hFFFF_FFFC;
        else if (st) nxt = mpc;
        else if (h)  nxt = t;
        else         nxt = mpc + 32'd4;
        if (up) begin
            i = idx_of(upc);
            if (tk) begin
                btb[i] = '{v: 1'b1, tag: tag_of(upc), tgt: utg & 32'hFFFF_FFFC};
            end else if (btb.exists(i) && btb[i].tag == tag_of(upc)) begin
                btb[i].v = 1'b0;
            end
        end
        mpc = nxt;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        tk;
        logic [31:0] tgt;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_exp(input string nm);
        exp_t      e;
        bit        h;
        bit [31:0] t;
        lookup(mpc, h, t);
        e.pc  = mpc;
        e.pc4 = mpc + 32'd4;
        e.tk  = h;
        e.tgt = t;
        e.nm  = nm;
        exp_q.push_back(e);
    endfunction

    // Monitor: the DUT presents a fresh PC/prediction after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, "_pc"},    pc_o,                  e.pc);
                chk({e.nm, "_pc4"},   pc_plus4_o,            e.pc4);
                chk({e.nm, "_taken"}, {31'b0, pred_taken_o}, {31'b0, e.tk});
                chk({e.nm, "_tgt"},   pred_target_o,         e.tgt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit up,
                         input bit tk, input logic [31:0] upc, input logic [31:0] utg,
                         input string nm);
        stall_i         = st;
        redirect_i      = rd;
        redirect_pc_i   = rpc;
        update_i        = up;
        update_taken_i  = tk;
        update_pc_i     = upc;
        update_target_i = utg;
        model_step(st, rd, rpc, up, tk, upc, utg);
        push_exp(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input string nm);
        cycle(0, 0, 0, 0, 0, 0, 0, nm);
    endtask

    task automatic train(input logic [31:0] upc, input logic [31:0] utg, input string nm);
        cycle(0, 0, 0, 1, 1, upc, utg, nm);
    endtask

    task automatic go(input logic [31:0] a, input string nm);
        cycle(0, 1, a, 0, 0, 0, 0, nm);
    endtask

    task automatic clear_inputs();
        stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        update_i = 0; update_taken_i = 0; update_pc_i = 0; update_target_i = 0;
    endtask

    // Reset lands mid-cycle with a redirect and a taken update pending; both must vanish.
    task automatic mid_reset();
        redirect_i = 1; redirect_pc_i = 32'h200;
        update_i = 1; update_taken_i = 1; update_pc_i = 32'h0; update_target_i = 32'h300;
        #2;
        rst = 1;
        #1;
        chk("arst_pc",    pc_o,                  RPC);
        chk("arst_taken", {31'b0, pred_taken_o}, 32'h0);
        chk("arst_tgt",   pred_target_o,         32'h0);
        model_reset();
        push_exp("arst_hold");
        @(posedge clk);
        #2;
        rst = 0;
        clear_inputs();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_FF00;
        return a;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        #2;
        chk("rst_pc",    pc_o,                  RPC);
        chk("rst_taken", {31'b0, pred_taken_o}, 32'h0);
        chk("rst_tgt",   pred_target_o,         32'h0);
        push_exp("rst_hold");
        @(posedge clk);
        #2;
        rst = 0;

        // Sequential fetch, wrapping out of the reset PC: 0, 4, 8, C, 10.
        idle("wrap");
        for (int i = 0; i < 4; i++) idle("seq");

        // Train 0x8 -> 0x40, then revisit 0x8 and follow the prediction.
        train(32'h8, 32'h40, "train8");
        go(32'h8, "visit8");
        idle("follow40");

        // Redirect beats stall and hit; low bits of the target are dropped.
        go(32'h8, "visit8b");
        cycle(1, 1, 32'h103, 0, 0, 0, 0, "redir_prio");

        // Stall holds a hitting PC; aliasing train at 0x48 replaces the 0x8 entry.
        go(32'h8, "visit8c");
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, "stall");
        cycle(1, 0, 0, 1, 1, 32'h48, 32'h80, "alias_wr");
        cycle(1, 0, 0, 0, 0, 0, 0, "alias_miss");
        idle("after_alias");

        // Not-taken on the current PC: hit still used this cycle, miss on the next visit.
        train(32'h8, 32'h40, "retrain8");
        go(32'h8, "visit8d");
        cycle(0, 0, 0, 1, 0, 32'h8, 32'h0, "nt_same");
        go(32'h8, "nt_miss");

        // Not-taken with a foreign tag leaves the entry alone.
        train(32'h8, 32'h40, "retrain8b");
        cycle(0, 0, 0, 1, 0, 32'h48, 32'h0, "nt_other");
        go(32'h8, "nt_kept");

        // Redirect and update in the same edge.
        cycle(0, 1, 32'h20, 1, 1, 32'h20, 32'h60, "redir_upd");
        idle("redir_upd_hit");

        // Async reset with work pending, then everything misses.
        idle("pre_arst");
        mid_reset();
        idle("post_arst");
        go(32'h8, "post_arst_miss");
        go(32'h20, "post_arst_miss2");

        for (int n = 0; n < 600; n++) begin
            logic        st, rd, up, tk;
            logic [31:0] rpc, upc, utg;
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 4) == 0);
            up  = ($urandom_range(0, 1) == 1);
            tk  = ($urandom_range(0, 2) != 0);
            rpc = pick_addr();
            upc = pick_addr();
            utg = pick_addr();
            cycle(st, rd, rpc, up, tk, upc, utg, "rand");
            if ($urandom_range(0, 99) == 0) mid_reset();
        end

        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_predictor.md
FETCH_PC_PREDICTOR -- requirements
Module: fetch_pc_predictor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/address width in bits.
REQ-002 SHALL have parameter BTB_DEPTH, default 16, meaning number of direct-mapped branch-target-buffer entries; legal values are powers of two, 2..256.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have port clk, in, 1, meaning clock; rising edge active.
REQ-005 SHALL have port rst, in, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port stall_i, in, 1, meaning hold the PC this cycle.
REQ-007 SHALL have port redirect_i, in, 1, meaning execute-stage correction: the next PC is redirect_pc_i.
REQ-008 SHALL have port redirect_pc_i, in, WIDTH, meaning corrected target (branch, JAL or JALR).
REQ-009 SHALL have port update_i, in, 1, meaning a resolved control-transfer instruction writes the BTB.
REQ-010 SHALL have port update_taken_i, in, 1, meaning the resolved instruction was taken.
REQ-011 SHALL have port update_pc_i, in, WIDTH, meaning address of the resolved instruction.
REQ-012 SHALL have port update_target_i, in, WIDTH, meaning resolved target address.
REQ-013 SHALL have port pc_o, out, WIDTH, meaning current fetch PC (registered).
REQ-014 SHALL have port pc_plus4_o, out, WIDTH, meaning pc_o + 4, wrapping modulo 2^WIDTH.
REQ-015 SHALL have port pred_taken_o, out, 1, meaning BTB hit for pc_o; the next PC is the predicted target.
REQ-016 SHALL have port pred_target_o, out, WIDTH, meaning predicted target; all zeros when pred_taken_o=0.

Function
REQ-017 SHALL define IW = log2(BTB_DEPTH), index = pc[IW+1:2] and tag = pc[WIDTH-1:IW+2]; PC bits [1:0] are ignored for lookup.
REQ-018 SHALL give each BTB entry a valid bit, a tag and a target of WIDTH-2 bits, stored word-aligned.
REQ-019 SHALL look up combinationally on pc_o, with hit = valid[index] AND (tag[index] == tag(pc_o)).
REQ-020 SHALL compute the next PC with priority redirect_i > stall_i > hit > pc_plus4_o.
REQ-021 SHALL on redirect load {redirect_pc_i[WIDTH-1:2], 2'b00}; the low two bits are forced to zero.
REQ-022 SHALL on stall without redirect hold pc_o unchanged; the prediction outputs SHALL stay consistent with the held pc_o.
REQ-023 SHALL load pred_target_o into the PC when a hit occurs with no stall and no redirect.
REQ-024 SHALL on update_i=1 with update_taken_i=1 write valid=1, the tag and the target into entry index(update_pc_i), overwriting any previous entry (no associativity).
REQ-025 SHALL on update_i=1 with update_taken_i=0 clear the valid bit only when the stored tag matches tag(update_pc_i); otherwise the entry is untouched.
REQ-026 SHALL perform BTB updates regardless of stall_i and redirect_i.
REQ-027 SHALL have a BTB write latency of one cycle: a lookup at the same index in the write cycle sees the old contents, and the new contents are visible from the next cycle.
REQ-028 SHALL leave PC update and BTB update independent; a simultaneous redirect and update both take effect in the same edge.
REQ-029 SHALL wrap the PC modulo 2^WIDTH with no overflow flag (0xFFFFFFFC + 4 -> 0x00000000).

Reset
REQ-030 SHALL while rst=1 force pc_o=RESET_PC asynchronously and clear all BTB valid bits, so that pred_taken_o=0 and pred_target_o=0.
REQ-031 SHALL discard, on reset asserted mid-operation, any pending redirect or update in that cycle.
REQ-032 SHALL leave BTB tag and target storage unreset, because valid bits gate all use.
REQ-033 SHALL on the first rising edge after rst deasserts, with no other inputs, give pc_o = RESET_PC + 4.

Verification
REQ-034 SHALL cover sequential fetch: reset, then 4 idle cycles -> pc_o sequence 0x0, 0x4, 0x8, 0xC, 0x10; pred_taken_o=0 throughout.
REQ-035 SHALL cover BTB train and hit: update_i, taken, update_pc=0x8, target=0x40 -> the next time pc_o=0x8, pred_taken_o=1, pred_target_o=0x40, and the next pc_o=0x40.
REQ-036 SHALL cover redirect priority: pc_o=0x8 hits as above, with stall_i=1, redirect_i=1 and redirect_pc_i=0x103 -> next pc_o=0x100.
REQ-037 SHALL cover stall hold plus aliasing: stall for 3 cycles holds pc_o; then train 0x48 (same index as 0x8 at depth 16) -> the 0x8 entry is replaced, and a lookup of 0x8 misses.
REQ-038 SHALL cover not-taken invalidation and the same-cycle write: a not-taken update for 0x8 while pc_o=0x8 -> hit still reported that cycle and a miss on the next visit; a not-taken update for a non-matching tag leaves the entry valid.
REQ-039 SHALL cover async reset and wrap: RESET_PC=0xFFFFFFFC with rst pulsed mid-cycle -> pc_o=0xFFFFFFFC immediately, then 0x00000000 after the next edge, with all BTB entries missing.
